jsilicon_uio_arbiter: RTL and testbench

Shares the 8-bit bidirectional `uio` pad bus among up to eight internal requesters, such as the UART TX, the debug/trace port and the ALU result port. It sits between those requesters and the top-level `uio_in`/`uio_out`/`uio_oe` pins. It grants ownership round-robin, locks the bus direction for each tenure, and inserts a one-cycle high-Z turnaround between owners so that no two drivers ever overlap. An optional tenure limit preempts owners that hog the bus.

---
 rtl/jsilicon_uio_arbiter_pkg.sv | 14 +
 rtl/jsilicon_uio_arbiter_if.sv | 26 ++
 rtl/jsilicon_uio_arbiter_rr_pick.sv | 34 +++
 rtl/jsilicon_uio_arbiter.sv | 139 +++++++++++++
 tb/tb_jsilicon_uio_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/jsilicon_uio_arbiter_pkg.sv
// rtl/jsilicon_uio_arbiter_pkg.sv - shared types and constants for the uio pad-bus arbiter
package jsilicon_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_MAX = 8;
  localparam int IDX_W       = $clog2(NUM_REQ_MAX);

  localparam logic [7:0] OE_DRIVE = 8'hFF;
  localparam logic [7:0] OE_HIZ   = 8'h00;
endpackage

// File: rtl/jsilicon_uio_arbiter_if.sv
// rtl/jsilicon_uio_arbiter_if.sv - requester/pad bundle between the requesters and the arbiter
interface jsilicon_uio_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                   ena;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     dir;
  logic [8*NUM_REQ-1:0]   wdata;
  logic [7:0]             uio_in;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     preempt;
  logic [7:0]             rdata;
  logic [NUM_REQ-1:0]     rd_valid;
  logic [7:0]             uio_out;
  logic [7:0]             uio_oe;

  modport master (
    output ena, req, dir, wdata, uio_in,
    input  grant, preempt, rdata, rd_valid, uio_out, uio_oe
  );

  modport slave (
    input  ena, req, dir, wdata, uio_in,
    output grant, preempt, rdata, rd_valid, uio_out, uio_oe
  );
endinterface

// File: rtl/jsilicon_uio_arbiter_rr_pick.sv
// rtl/jsilicon_uio_arbiter_rr_pick.sv - combinational round-robin picker (module jsilicon_rr_pick)
module jsilicon_rr_pick
  import jsilicon_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);
  logic found;

  // Two passes: requesters at or above the pointer first, then wrap to the low ones.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/jsilicon_uio_arbiter.sv
// rtl/jsilicon_uio_arbiter.sv - round-robin owner of the uio pad bus with high-Z turnaround
// Optional tenure limit: define JSILICON_UIO_ARB_TIMEOUT_EN.
module jsilicon_uio_arbiter
  import jsilicon_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  jsilicon_uio_arbiter_if.slave   bus
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_OWN  = OWN;
  localparam logic [1:0] S_TURN = TURN;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                dir_q, dir_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  preempt_q, preempt_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [7:0]          uio_out_q, uio_out_d;

  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic [7:0]          wsel;
  logic                owner_req, others_req, timeout;

  jsilicon_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign owner_req  = |(bus.req & grant_q);
  assign others_req = |(bus.req & ~grant_q);

  always_comb begin
    wsel = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) wsel = bus.wdata[8*i +: 8];
    end
  end

`ifdef JSILICON_UIO_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter is zero on entry to OWN and saturates at HOLD_MAX.
  always_comb begin
    cnt_d = 8'd0;
    if (state_q == S_OWN) begin
      cnt_d = (cnt_q == 8'(HOLD_MAX)) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q >= 8'(HOLD_MAX - 1)) && others_req;
`else
  logic unused_cfg;
  assign unused_cfg = ^{others_req, 8'(HOLD_MAX)};
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dir_d      = dir_q;
    grant_d    = grant_q;
    preempt_d  = '0;
    rd_valid_d = '0;
    rdata_d    = rdata_q;
    uio_out_d  = 8'h00;
    case (state_q)
      S_OWN: begin
        if (dir_q) begin
          uio_out_d = wsel;
        end else begin
          rdata_d    = bus.uio_in;
          rd_valid_d = grant_q;
        end
        // A release coinciding with a timeout is an ordinary release, not a preemption.
        if (!owner_req || timeout) begin
          state_d   = S_TURN;
          grant_d   = '0;
          uio_out_d = 8'h00;
          if (owner_req) preempt_d = grant_q;
        end
      end
      default: begin
        if (bus.ena && (|bus.req)) begin
          state_d = S_OWN;
          grant_d = pick;
          dir_d   = |(bus.dir & pick);
          ptr_d   = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      dir_q      <= 1'b0;
      grant_q    <= '0;
      preempt_q  <= '0;
      rd_valid_q <= '0;
      rdata_q    <= 8'h00;
      uio_out_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dir_q      <= dir_d;
      grant_q    <= grant_d;
      preempt_q  <= preempt_d;
      rd_valid_q <= rd_valid_d;
      rdata_q    <= rdata_d;
      uio_out_q  <= uio_out_d;
    end
  end

  // Output enable is decoded from registered state so reset blanks it immediately.
  assign bus.uio_oe   = (state_q == S_OWN && dir_q) ? OE_DRIVE : OE_HIZ;
  assign bus.grant    = grant_q;
  assign bus.preempt  = preempt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rdata    = rdata_q;
  assign bus.uio_out  = uio_out_q;
endmodule

// File: tb/tb_jsilicon_uio_arbiter.sv
// tb/tb_jsilicon_uio_arbiter.sv - directed self-checking bench for jsilicon_uio_arbiter
module tb_jsilicon_uio_arbiter;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  int   e;

  jsilicon_uio_arbiter_if #(.NUM_REQ(4)) bus ();

  jsilicon_uio_arbiter #(.NUM_REQ(4), .HOLD_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.ena    = 1'b1;
    bus.req    = 4'b0000;
    bus.dir    = 4'b0000;
    bus.wdata  = 32'h0;
    bus.uio_in = 8'h00;
    #3;
    check("rst_grant",    32'(bus.grant),    32'h0);
    check("rst_preempt",  32'(bus.preempt),  32'h0);
    check("rst_rdata",    32'(bus.rdata),    32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_uio_out",  32'(bus.uio_out),  32'h0);
    check("rst_uio_oe",   32'(bus.uio_oe),   32'h0);

    // First write tenure for requester 0
    rst_n     = 1'b1;
    bus.req   = 4'b0001;
    bus.dir   = 4'b0001;
    bus.wdata = 32'h000000A5;
    tick();
    check("wr_grant",   32'(bus.grant),   32'h1);
    check("wr_oe",      32'(bus.uio_oe),  32'hFF);
    check("wr_out_lat", 32'(bus.uio_out), 32'h00);
    tick();
    check("wr_out", 32'(bus.uio_out), 32'hA5);
    bus.req = 4'b0000;
    tick();
    check("wr_turn_grant", 32'(bus.grant),   32'h0);
    check("wr_turn_oe",    32'(bus.uio_oe),  32'h0);
    check("wr_turn_out",   32'(bus.uio_out), 32'h0);
    tick();

    // Round-robin from a fresh pointer
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    bus.req   = 4'b1111;
    bus.dir   = 4'b1111;
    bus.wdata = 32'h44332211;
    for (int n = 0; n < 5; n++) begin
      e = n % 4;
      tick();
      check("rr_grant", 32'(bus.grant),  32'h1 << e);
      check("rr_oe",    32'(bus.uio_oe), 32'hFF);
      tick();
      check("rr_out",   32'(bus.uio_out), (32'h44332211 >> (8 * e)) & 32'hFF);
      bus.req[e] = 1'b0;
      tick();
      check("rr_turn_grant", 32'(bus.grant),  32'h0);
      check("rr_turn_oe",    32'(bus.uio_oe), 32'h0);
      if (n < 4) bus.req[e] = 1'b1;
    end
    bus.req = 4'b0000;
    tick();
    check("rr_idle_grant", 32'(bus.grant), 32'h0);

    // Read tenure for requester 2
    bus.req    = 4'b0100;
    bus.dir    = 4'b0000;
    bus.uio_in = 8'h3C;
    tick();
    check("rd_grant", 32'(bus.grant),  32'h4);
    check("rd_oe",    32'(bus.uio_oe), 32'h0);
    bus.dir = 4'b1111;
    tick();
    check("rd_rdata",    32'(bus.rdata),    32'h3C);
    check("rd_valid",    32'(bus.rd_valid), 32'h4);
    check("rd_out",      32'(bus.uio_out),  32'h0);
    check("rd_dir_lock", 32'(bus.uio_oe),   32'h0);
    bus.uio_in = 8'h5A;
    tick();
    check("rd_rdata2", 32'(bus.rdata), 32'h5A);
    bus.req = 4'b0000;
    tick();
    check("rd_turn_grant", 32'(bus.grant),    32'h0);
    check("rd_turn_valid", 32'(bus.rd_valid), 32'h4);
    tick();
    check("rd_idle_valid", 32'(bus.rd_valid), 32'h0);

    // Tenure limit: pointer is 3, so requester 0 wins first
    bus.req = 4'b0011;
    bus.dir = 4'b0011;
    tick();
    check("to_grant0", 32'(bus.grant), 32'h1);
    for (int k = 0; k < 14; k++) tick();
    check("to_hold14", 32'(bus.grant),   32'h1);
    check("to_nopre",  32'(bus.preempt), 32'h0);
    tick();
`ifdef JSILICON_UIO_ARB_TIMEOUT_EN
    check("to_turn_grant", 32'(bus.grant),   32'h0);
    check("to_preempt",    32'(bus.preempt), 32'h1);
    tick();
    check("to_next_grant", 32'(bus.grant),   32'h2);
    check("to_pre_clear",  32'(bus.preempt), 32'h0);
`else
    check("to_keep_grant", 32'(bus.grant),   32'h1);
    check("to_no_preempt", 32'(bus.preempt), 32'h0);
    for (int k = 0; k < 10; k++) tick();
    check("to_keep_long",  32'(bus.grant),   32'h1);
`endif
    bus.req = 4'b0000;
    tick();
    tick();

    // Async reset mid write tenure, then ena gating from a reset pointer
    bus.req   = 4'b0001;
    bus.dir   = 4'b0001;
    bus.wdata = 32'h000000A5;
    tick();
    tick();
    check("ar_out_pre", 32'(bus.uio_out), 32'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_oe",    32'(bus.uio_oe),  32'h0);
    check("ar_grant", 32'(bus.grant),   32'h0);
    check("ar_out",   32'(bus.uio_out), 32'h0);
    bus.ena = 1'b0;
    bus.req = 4'b0011;
    rst_n   = 1'b1;
    tick();
    tick();
    check("ena_off_grant", 32'(bus.grant), 32'h0);
    bus.ena = 1'b1;
    tick();
    check("ena_on_grant", 32'(bus.grant), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
